// File: rtl/sync_pkg.sv
// Shared definitions for the multi-channel input conditioner.
//   SYNC_STAGES_DEF / DEBOUNCE_DEF : default synchroniser depth and debounce length
//   cnt_w()                        : debounce counter width for a given length
//   edge_t                         : registered rise/fall pulse pair of one channel
package sync_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEBOUNCE_DEF    = 4;

    // One extra code point of headroom so the width is never zero.
    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input bit: flop synchroniser, debounce counter, accepted level
// and registered edge pulses.
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high
//   hold    in   1 = freeze level, clear counter, suppress pulses
//   in_raw  in   asynchronous raw input bit
//   level_o out  debounced level
//   rise_o  out  1-cycle pulse when level_o goes 0->1
//   fall_o  out  1-cycle pulse when level_o goes 1->0
module debounce_channel
    import sync_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic in_raw,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    edge_t                  pulse_q, pulse_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], in_raw};
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = '0;
        // The chain keeps shifting under hold so a released hold sees fresh data,
        // but any partial count is discarded and must be rebuilt from zero.
        if (hold) begin
            cnt_d = '0;
        end else if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d      = s;
            cnt_d        = '0;
            pulse_d.rise = s;
            pulse_d.fall = ~s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = pulse_q.rise;
    assign fall_o  = pulse_q.fall;

endmodule

// File: rtl/sync_debounce_n.sv
// Multi-channel input conditioner: WIDTH independent synchronise+debounce
// channels with a combined change indicator.
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high
//   hold     in   1 = freeze levels, clear counters, suppress pulses
//   in_raw   in   [WIDTH] asynchronous raw inputs
//   level_o  out  [WIDTH] debounced levels
//   rise_o   out  [WIDTH] 1-cycle rising-edge pulses
//   fall_o   out  [WIDTH] 1-cycle falling-edge pulses
//   change_o out  any rise or fall pulse this cycle
module sync_debounce_n
    import sync_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             change_o
);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_debounce_n: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("sync_debounce_n: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("sync_debounce_n: DEBOUNCE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .hold   (hold),
            .in_raw (in_raw[i]),
            .level_o(level_o[i]),
            .rise_o (rise_o[i]),
            .fall_o (fall_o[i])
        );
    end

    // Built from the registered pulses, so it is glitch-free and in phase with them.
    assign change_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_sync_debounce_n.sv
module tb_sync_debounce_n;

    logic       clk = 1'b0;
    logic       reset, hold;
    logic [3:0] in_raw;
    logic [3:0] level_o, rise_o, fall_o;
    logic       change_o;

    sync_debounce_n #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold),
        .in_raw  (in_raw),
        .level_o (level_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .change_o(change_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic exp_at(input int c, input logic [3:0] l, input logic [3:0] r,
                          input logic [3:0] f, input string tag);
        exp_t e;
        e.cyc = c; e.lvl = l; e.rise = r; e.fall = f; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic quiet(input int c0, input int c1, input logic [3:0] l, input string tag);
        for (int c = c0; c <= c1; c++) exp_at(c, l, 4'h0, 4'h0, tag);
    endtask

    // Advance one edge, then compare every expectation due at this cycle.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            chk({e.tag, "_due"}, 32'(e.cyc), 32'(cyc));
            chk({e.tag, "_lvl"},  32'(level_o),  32'(e.lvl));
            chk({e.tag, "_rise"}, 32'(rise_o),   32'(e.rise));
            chk({e.tag, "_fall"}, 32'(fall_o),   32'(e.fall));
            chk({e.tag, "_chg"},  32'(change_o), 32'(|(e.rise | e.fall)));
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // 1: reset with all inputs high, then release
        reset = 1'b1; hold = 1'b0; in_raw = 4'hF;
        quiet(1, 2, 4'h0, "t1_rst");
        step(); step();
        reset = 1'b0;
        c = cyc;
        quiet(c + 1, c + 5, 4'h0, "t1_wait");
        exp_at(c + 6, 4'hF, 4'hF, 4'h0, "t1_rise");
        quiet(c + 7, c + 7, 4'hF, "t1_after");
        run_to(c + 7);

        // all channels back low, exercising simultaneous falls
        in_raw = 4'h0;
        c = cyc;
        quiet(c + 1, c + 5, 4'hF, "t1f_wait");
        exp_at(c + 6, 4'h0, 4'h0, 4'hF, "t1f_fall");
        quiet(c + 7, c + 7, 4'h0, "t1f_after");
        run_to(c + 7);

        // 2a: 3-cycle pulse on ch0 must be rejected
        c = cyc;
        in_raw[0] = 1'b1;
        quiet(c + 1, c + 10, 4'h0, "t2_glitch");
        run_to(c + 3);
        in_raw[0] = 1'b0;
        run_to(c + 10);

        // 2b: 4-cycle pulse on ch0 is accepted, then released
        c = cyc;
        in_raw[0] = 1'b1;
        quiet(c + 1, c + 5, 4'h0, "t2_wait");
        exp_at(c + 6, 4'h1, 4'h1, 4'h0, "t2_rise");
        quiet(c + 7, c + 9, 4'h1, "t2_high");
        exp_at(c + 10, 4'h0, 4'h0, 4'h1, "t2_fall");
        quiet(c + 11, c + 12, 4'h0, "t2_low");
        run_to(c + 4);
        in_raw[0] = 1'b0;
        run_to(c + 12);

        // 3: ch1 bounces for 10 cycles, then settles high
        c = cyc;
        quiet(c + 1, c + 15, 4'h0, "t3_bounce");
        exp_at(c + 16, 4'h2, 4'h2, 4'h0, "t3_rise");
        quiet(c + 17, c + 18, 4'h2, "t3_high");
        for (int k = 0; k < 10; k++) begin
            in_raw[1] = (k % 2 == 0);
            step();
        end
        in_raw[1] = 1'b1;
        run_to(c + 18);

        // 4: ch2 rises while hold is asserted
        c = cyc;
        hold = 1'b1;
        in_raw[2] = 1'b1;
        quiet(c + 1, c + 11, 4'h2, "t4_hold");
        exp_at(c + 12, 4'h6, 4'h4, 4'h0, "t4_rise");
        quiet(c + 13, c + 14, 4'h6, "t4_high");
        run_to(c + 8);
        hold = 1'b0;
        run_to(c + 14);

        // 5: reset lands just before ch3 would be accepted
        c = cyc;
        in_raw[3] = 1'b1;
        quiet(c + 1, c + 5, 4'h6, "t5_count");
        quiet(c + 6, c + 11, 4'h0, "t5_rst");
        exp_at(c + 12, 4'hE, 4'hE, 4'h0, "t5_rise");
        quiet(c + 13, c + 14, 4'hE, "t5_high");
        run_to(c + 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_to(c + 14);

        // 6 setup: settle at level 4'b0100
        c = cyc;
        in_raw = 4'b0100;
        quiet(c + 1, c + 5, 4'hE, "t6s_wait");
        exp_at(c + 6, 4'b0100, 4'h0, 4'b1010, "t6s_fall");
        quiet(c + 7, c + 8, 4'b0100, "t6s_after");
        run_to(c + 8);

        // 6: rise on ch1 and fall on ch2 in the same cycle
        c = cyc;
        in_raw = 4'b0010;
        quiet(c + 1, c + 5, 4'b0100, "t6_wait");
        exp_at(c + 6, 4'b0010, 4'b0010, 4'b0100, "t6_both");
        quiet(c + 7, c + 8, 4'b0010, "t6_after");
        run_to(c + 8);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
